// File: rtl/udp_pkg.sv
// Shared types for the UDP packet buffer: stored word layout and write-side FSM states.
// Pure declarations; no timing or flow control of its own.
package udp_pkg;

    localparam int TID_MAX = 8;

    typedef struct packed {
        logic [TID_MAX-1:0] tid;
        logic [31:0]        tdata;
        logic [3:0]         tkeep;
        logic               tlast;
    } word_t;

    typedef enum logic {
        ACCEPT = 1'b0,
        DROP   = 1'b1
    } wr_state_t;

endpackage

// File: rtl/udp_pkt_buffer_ram.sv
// Simple dual-port word store, one write and one read port; registered read, 1-cycle latency.
// No flow control; the caller owns address ordering and never reads a slot being written.
module udp_pkt_buffer_ram
    import udp_pkg::*;
#(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  word_t                 wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output word_t                 rd_data
);

    word_t mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/udp_pkt_buffer.sv
// Store-and-forward packet FIFO; m_tvalid 2 cycles after the committing s_tlast edge.
// Never backpressures the input (overflowing packets are dropped); output obeys m_tready via a 2-entry skid.
module udp_pkt_buffer
    import udp_pkg::*;
#(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ID_WIDTH-1:0]   s_tid,
    input  logic [31:0]           s_tdata,
    input  logic [3:0]            s_tkeep,
    input  logic                  s_tlast,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic [ID_WIDTH-1:0]   m_tid,
    output logic [31:0]           m_tdata,
    output logic [3:0]            m_tkeep,
    output logic                  m_tlast,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [ADDR_WIDTH:0]   pkt_cnt,
    output logic [15:0]           drop_cnt,
    output logic                  drop_pulse
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr;
    wr_state_t     state, state_nx;
    logic          accept, full;
    logic          wr_en, commit, rewind, drop_evt;
    word_t         wr_word, ram_q, head, tail;
    logic          rd_en, ram_vld, pop, pkt_done;
    logic [1:0]    occ;
    logic [2:0]    fill_nx;
    logic          unused_tid;

    assign accept = s_tvalid & s_tready;
    // Registered pointers only: a read this cycle does not free space for this cycle's write.
    assign full   = (wr_ptr - rd_ptr) == DEPTH;

    always_comb begin
        wr_word.tid   = TID_MAX'(s_tid);
        wr_word.tdata = s_tdata;
        wr_word.tkeep = s_tkeep;
        wr_word.tlast = s_tlast;
    end

    always_comb begin
        state_nx = state;
        wr_en    = 1'b0;
        commit   = 1'b0;
        rewind   = 1'b0;
        drop_evt = 1'b0;
        case (state)
            ACCEPT: begin
                if (accept) begin
                    if (full) begin
                        rewind = 1'b1;
                        if (s_tlast) begin
                            drop_evt = 1'b1;
                        end else begin
                            state_nx = DROP;
                        end
                    end else begin
                        wr_en  = 1'b1;
                        commit = s_tlast;
                    end
                end
            end
            DROP: begin
                if (accept && s_tlast) begin
                    drop_evt = 1'b1;
                    state_nx = ACCEPT;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ACCEPT;
            s_tready   <= 1'b0;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            drop_cnt   <= '0;
            drop_pulse <= 1'b0;
        end else begin
            state      <= state_nx;
            s_tready   <= 1'b1;
            drop_pulse <= drop_evt;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end else if (rewind) begin
                wr_ptr <= commit_ptr;
            end
            if (commit) begin
                commit_ptr <= wr_ptr + PW'(1);
            end
            if (drop_evt && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    udp_pkt_buffer_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
        .wr_data (wr_word),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data (ram_q)
    );

    assign pop      = (occ != 2'd0) & m_tready;
    assign pkt_done = pop & head.tlast;
    // Skid occupancy after this edge, counting the word already in flight from the RAM.
    assign fill_nx  = {1'b0, occ} + {2'b0, ram_vld} - {2'b0, pop};
    assign rd_en    = (rd_ptr != commit_ptr) && (fill_nx < 3'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr  <= '0;
            ram_vld <= 1'b0;
            occ     <= 2'd0;
            head    <= '0;
            tail    <= '0;
            pkt_cnt <= '0;
        end else begin
            ram_vld <= rd_en;
            occ     <= fill_nx[1:0];
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (pop) begin
                if (occ == 2'd2) begin
                    head <= tail;
                    if (ram_vld) begin
                        tail <= ram_q;
                    end
                end else if (ram_vld) begin
                    head <= ram_q;
                end
            end else if (ram_vld) begin
                if (occ == 2'd0) begin
                    head <= ram_q;
                end else begin
                    tail <= ram_q;
                end
            end
            if (commit && !pkt_done) begin
                pkt_cnt <= pkt_cnt + PW'(1);
            end else if (pkt_done && !commit) begin
                pkt_cnt <= pkt_cnt - PW'(1);
            end
        end
    end

    assign m_tvalid   = (occ != 2'd0);
    assign m_tid      = head.tid[ID_WIDTH-1:0];
    assign m_tdata    = head.tdata;
    assign m_tkeep    = head.tkeep;
    assign m_tlast    = head.tlast;
    assign unused_tid = ^head.tid;

endmodule

// File: doc/udp_pkt_buffer.md
UDP_PKT_BUFFER -- requirements
Module: udp_pkt_buffer

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 1, meaning the stream tid width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, meaning log2 of the buffer depth in 32-bit words.
REQ-003 SHALL have one clock and a synchronous, active-high reset, with ports as follows:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- s_tid  in  ID_WIDTH  input packet id.
- s_tdata  in  32  input data.
- s_tkeep  in  4  input byte enables.
- s_tlast  in  1  last word of the input packet.
- s_tvalid  in  1  input word valid.
- s_tready  out  1  input ready.
- m_tid, m_tdata, m_tkeep, m_tlast, m_tvalid  out  as the s_ ports; output stream toward the UDP packet builder.
- m_tready  in  1  output ready.
- pkt_cnt  out  ADDR_WIDTH+1  committed packets not yet fully read.
- drop_cnt  out  16  dropped packets, saturating.
- drop_pulse  out  1  one-cycle strobe per dropped packet.

Function
REQ-004 SHALL be a store-and-forward packet FIFO: no word of a packet appears on m_ until its s_tlast word has been written.
REQ-005 SHALL hold s_tready=1 whenever reset is low; it never backpressures and drops on overflow.
REQ-006 SHALL store tid, tdata, tkeep and tlast per word and pass them through unmodified, with no tkeep checking.
REQ-007 SHALL keep three ADDR_WIDTH+1-bit pointers, wr_ptr, commit_ptr and rd_ptr, each wrapping at 2^(ADDR_WIDTH+1).
- full = (wr_ptr - rd_ptr) == 2^ADDR_WIDTH.
- full is evaluated on registered pointers, so a read in the same cycle does not free space.
REQ-008 SHALL run a write FSM with states ACCEPT and DROP.
- ACCEPT, word accepted, not full: write the word at wr_ptr; wr_ptr+1.
- If that word has s_tlast=1: commit_ptr <= wr_ptr+1 and pkt_cnt+1.
REQ-009 SHALL handle overflow in ACCEPT as follows:
- Word accepted while full: wr_ptr <= commit_ptr and the word is discarded.
- If that word has s_tlast=0: go to DROP.
- If that word has s_tlast=1: count the drop and stay in ACCEPT.
REQ-010 SHALL, in DROP, discard every word.
- On the s_tlast word: go to ACCEPT, increment drop_cnt (saturating at 0xFFFF) and pulse drop_pulse for exactly 1 cycle.
REQ-011 SHALL always drop a packet longer than 2^ADDR_WIDTH words, leaving earlier committed packets intact.
REQ-012 SHALL read only while rd_ptr != commit_ptr; RAM read latency is 1 cycle.
REQ-013 SHALL assert m_tvalid exactly 2 cycles after the edge that accepts s_tlast when the output stage is empty.
REQ-014 SHALL sustain 1 word/cycle on m_ while m_tready=1 and committed data exists, including across packet boundaries, using a 2-entry output skid.
REQ-015 SHALL hold m_tid, m_tdata, m_tkeep, m_tlast and m_tvalid stable while m_tvalid=1 and m_tready=0.
REQ-016 SHALL decrement pkt_cnt on an m_tlast handshake; a simultaneous commit and m_tlast handshake SHALL leave pkt_cnt unchanged.
REQ-017 SHALL deliver packets in arrival order with words in order.

Reset
REQ-018 SHALL, while reset is high, drive:
- s_tready=0, m_tvalid=0, drop_pulse=0.
- pkt_cnt=0, drop_cnt=0.
- wr_ptr=commit_ptr=rd_ptr=0, FSM in ACCEPT, skid empty.
- m_tid, m_tdata, m_tkeep, m_tlast = 0.
REQ-019 SHALL discard any partial input packet on reset; s_tready rises in the first cycle after reset goes low.
REQ-020 SHALL NOT reset the RAM contents.

Structure
REQ-021 SHALL take the stored-word packed struct {tid, tdata, tkeep, tlast} and the FSM state enum from the shared package udp_pkg.
REQ-022 SHALL put storage in one sub-module, udp_pkt_buffer_ram.
- Simple dual-port: one write port, one read port.
- Registered read, no reset.

Verification
REQ-023 Single packet: 4 words tid=1, tdata 0x1..0x4, last tkeep=0x3, m_tready=1 -> identical 4 words on m_ in 4 consecutive cycles, m_tvalid rising 2 cycles after tlast, pkt_cnt 1->0.
REQ-024 Backpressure: 8-word packet, m_tready pattern 1,0,1,0... -> m_ held stable while stalled, all 8 words in order, no loss.
REQ-025 Overflow: ADDR_WIDTH=4, 10-word packet A unread, then 10-word packet B -> B dropped, drop_cnt=1, one drop_pulse; A read intact; then 6-word C accepted and read intact.
REQ-026 Oversize: ADDR_WIDTH=4, empty buffer, 20-word packet -> dropped, drop_cnt=1, pkt_cnt=0, m_tvalid never asserted.
REQ-027 Reset mid-packet: reset high after 3 of 8 words -> m_tvalid=0, counters 0; next 2-word packet delivered cleanly.
REQ-028 Streaming: 100 back-to-back 1-word packets with m_tready=1 -> 100 words out at 1/cycle after 2-cycle latency, pkt_cnt ends at 0, drop_cnt=0.
